uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
- Runtime-configurable UART receiver for the SoC peripheral bus. Successor to the fixed 8N1 receiver.
- Adds an input synchroniser and a start-bit glitch filter.
- Frame format is configurable: 5–8 data bits, none/even/odd parity, 1 or 2 stop bits.
- Reports per-frame parity and framing errors and detects break conditions.
- Received data sits in a one-entry output register with a valid/ready handshake and overrun reporting.

Parameters:
- CNT_WIDTH, 16, width of the bit-period counter and of wait_cycles.
- SYNC_STAGES, 2, flops in the rx synchroniser (minimum 2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset: synchronous, active-low.
- rx  input  1  asynchronous serial line, idle high.
- wait_cycles  input  CNT_WIDTH  bit period minus 1, in clk cycles.
- data_bits  input  2  data bits per frame: 0=5, 1=6, 2=7, 3=8.
- parity_mode  input  2  0=none, 1=even, 2=odd, 3=none.
- two_stop  input  1  1 = two stop bits expected.
- rx_data  output  8  received byte, LSB-aligned, unused upper bits 0.
- rx_valid  output  1  rx_data holds an unread frame.
- rx_ready  input  1  consumer accepts rx_data.
- parity_err  output  1  parity mismatch for the frame in rx_data; qualified by rx_valid.
- frame_err  output  1  a stop bit was sampled low for the frame in rx_data; qualified by rx_valid.
- overrun  output  1  one-cycle pulse: a completed frame was dropped.
- break_det  output  1  one-cycle pulse: break detected.

Behaviour:
- Reset (rst_n low at a clk edge):
  - All outputs 0; FSM in IDLE; counter 0.
  - Synchroniser flops set to 1.
  - Reset mid-frame abandons the frame with no pulses.
- Sampling: all line logic uses the synchronised signal rxs. Bit period = wait_cycles+1 cycles.
- Config latching: data_bits, parity_mode, two_stop and wait_cycles are latched on the IDLE→START transition. Changes mid-frame have no effect.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH.
- IDLE: on rxs==0, go to START and load counter = wait_cycles>>1.
- START:
  - Count down; at counter==0, sample rxs.
  - If rxs==0, go to DATA: load wait_cycles, bit index 0, clear shift register and parity accumulator.
  - If rxs==1, this is a glitch: return to IDLE with no output.
- DATA:
  - Sample at counter==0, then reload wait_cycles.
  - Bits are stored LSB first at rx_data[index]; parity accumulator XORs each bit.
  - After bit (N-1), go to PARITY if parity is enabled, else STOP1.
- PARITY: sample at counter==0.
  - Even mode error if (acc XOR bit)==1.
  - Odd mode error if (acc XOR bit)==0.
- STOP1:
  - Sample at counter==0; a low sample sets the frame error.
  - If two_stop==1, go to STOP2; otherwise complete the frame.
- STOP2: same check as STOP1; then complete the frame.
- Frame completion (cycle of the final stop sample):
  - Break: all data bits 0, parity bit 0 (if enabled), and first stop 0.
    - Pulse break_det the next cycle.
    - Do not load the output register.
    - Go to WAIT_HIGH.
  - Otherwise, the result is loaded into the output register. rx_valid, rx_data, parity_err and frame_err update the next cycle.
  - After completion, go to IDLE if rxs==1, else WAIT_HIGH.
- WAIT_HIGH: stay until rxs==1, then IDLE. A low line never retriggers a start.
- Output handshake:
  - rx_valid stays high until a cycle with rx_valid && rx_ready; it clears the next cycle.
  - rx_data and the error flags are stable while rx_valid is high.
- Simultaneous completion and pop: the new frame is loaded, rx_valid stays 1, no overrun.
- Completion while rx_valid==1 and rx_ready==0:
  - The new frame is discarded; the old frame is retained.
  - overrun pulses for one cycle.
- Latency: rx_valid rises one clk after the centre sample of the last stop bit, plus SYNC_STAGES cycles of synchroniser delay relative to the line.
- wait_cycles==0 is legal: period = 1 cycle, start check immediately.
- No wrap of the counter: the counter only reloads at 0.

Test Plan:
- 8N1, wait_cycles=9, send 0xA5, rx_ready=1 -> rx_valid pulses once with rx_data=0xA5, parity_err=0, frame_err=0.
- 7E1, send 0x35 with correct parity bit 0 -> rx_data=0x35, parity_err=0; resend with parity bit 1 -> parity_err=1, rx_valid=1.
- 5O2, send 0x1F, second stop driven low -> rx_data=0x1F, frame_err=1.
- rx low for 3 cycles only (wait_cycles=9) -> no rx_valid; FSM back in IDLE; a following 0x3C is received correctly.
- Hold rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun pulses once; after pop, rx_valid=0.
- Line held low 30 bit periods (8N1) -> one break_det pulse, no rx_valid. Then raise rx and send 0x7E -> received. Also: assert rst_n=0 mid-byte -> all outputs 0, no pulses.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: rx synchroniser, start-bit glitch
// filter, 5-8 data bits, none/even/odd parity, 1 or 2 stop bits, break
// detection and a one-entry valid/ready output register with overrun.
module uart_rx_cfg #(
   parameter int CNT_WIDTH   = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   input  logic [CNT_WIDTH-1:0] wait_cycles,
   input  logic [1:0]           data_bits,
   input  logic [1:0]           parity_mode,
   input  logic                 two_stop,
   output logic [7:0]           rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 break_det
);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_WAIT_HIGH
   } state_t;

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_rxs;

   state_t                 r_state;
   logic [CNT_WIDTH-1:0]   r_cnt;
   logic [CNT_WIDTH-1:0]   r_wait;
   logic [2:0]             r_last_idx;
   logic                   r_par_en;
   logic                   r_par_odd;
   logic                   r_two_stop;
   logic [2:0]             r_idx;
   logic [7:0]             r_shift;
   logic                   r_acc;
   logic                   r_nonzero;
   logic                   r_perr;
   logic                   r_ferr;

   logic [7:0]             r_data;
   logic                   r_valid;
   logic                   r_perr_o;
   logic                   r_ferr_o;
   logic                   r_overrun;
   logic                   r_break;

   logic                   w_tick;
   logic                   w_done;
   logic                   w_ferr_fin;
   logic                   w_stop1_low;
   logic                   w_break;
   logic                   w_deliver;

   assign w_rxs = r_sync[SYNC_STAGES-1];

   // Synchroniser: idles high so reset never looks like a start bit
   always_ff @(posedge clk) begin
      if (!rst_n) r_sync <= '1;
      else        r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
   end

   // Frame completion and break decode in the cycle of the final stop sample
   always_comb begin
      w_tick      = (r_cnt == '0);
      w_done      = w_tick && ((r_state == S_STOP1 && !r_two_stop) || r_state == S_STOP2);
      // After STOP1 in two-stop mode, r_ferr holds exactly "first stop was low"
      w_ferr_fin  = (r_state == S_STOP2) ? (r_ferr | ~w_rxs) : ~w_rxs;
      w_stop1_low = (r_state == S_STOP2) ? r_ferr : ~w_rxs;
      w_break     = w_done && !r_nonzero && w_stop1_low;
      w_deliver   = w_done && !w_break;
   end

   // Receive FSM: config latched at frame start, centre sampling via down-counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_wait     <= '0;
         r_last_idx <= '0;
         r_par_en   <= 1'b0;
         r_par_odd  <= 1'b0;
         r_two_stop <= 1'b0;
         r_idx      <= '0;
         r_shift    <= '0;
         r_acc      <= 1'b0;
         r_nonzero  <= 1'b0;
         r_perr     <= 1'b0;
         r_ferr     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (!w_rxs) begin
                  r_wait     <= wait_cycles;
                  r_last_idx <= 3'(data_bits) + 3'd4;
                  r_par_en   <= (parity_mode == 2'd1) || (parity_mode == 2'd2);
                  r_par_odd  <= (parity_mode == 2'd2);
                  r_two_stop <= two_stop;
                  r_idx      <= '0;
                  r_shift    <= '0;
                  r_acc      <= 1'b0;
                  r_nonzero  <= 1'b0;
                  r_perr     <= 1'b0;
                  r_ferr     <= 1'b0;
                  // A one-cycle bit leaves no room for a separate start check:
                  // the detection itself is the start-bit sample.
                  if (wait_cycles == '0) begin
                     r_cnt   <= '0;
                     r_state <= S_DATA;
                  end else begin
                     r_cnt   <= wait_cycles >> 1;
                     r_state <= S_START;
                  end
               end
            end
            S_START: begin
               if (!w_tick)     r_cnt <= r_cnt - CNT_WIDTH'(1);
               else if (!w_rxs) begin
                  r_cnt   <= r_wait;
                  r_state <= S_DATA;
               end else         r_state <= S_IDLE;
            end
            S_DATA: begin
               if (!w_tick) r_cnt <= r_cnt - CNT_WIDTH'(1);
               else begin
                  r_shift[r_idx] <= w_rxs;
                  r_acc          <= r_acc ^ w_rxs;
                  r_nonzero      <= r_nonzero | w_rxs;
                  r_cnt          <= r_wait;
                  if (r_idx == r_last_idx) r_state <= r_par_en ? S_PARITY : S_STOP1;
                  else                     r_idx   <= r_idx + 3'd1;
               end
            end
            S_PARITY: begin
               if (!w_tick) r_cnt <= r_cnt - CNT_WIDTH'(1);
               else begin
                  r_perr    <= r_par_odd ? ~(r_acc ^ w_rxs) : (r_acc ^ w_rxs);
                  r_nonzero <= r_nonzero | w_rxs;
                  r_cnt     <= r_wait;
                  r_state   <= S_STOP1;
               end
            end
            S_STOP1: begin
               if (!w_tick) r_cnt <= r_cnt - CNT_WIDTH'(1);
               else if (r_two_stop) begin
                  r_ferr  <= ~w_rxs;
                  r_cnt   <= r_wait;
                  r_state <= S_STOP2;
               end else   r_state <= (w_break || !w_rxs) ? S_WAIT_HIGH : S_IDLE;
            end
            S_STOP2: begin
               if (!w_tick) r_cnt   <= r_cnt - CNT_WIDTH'(1);
               else         r_state <= (w_break || !w_rxs) ? S_WAIT_HIGH : S_IDLE;
            end
            S_WAIT_HIGH: begin
               if (w_rxs) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Output register: load on completion if empty or being popped, else overrun
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_perr_o  <= 1'b0;
         r_ferr_o  <= 1'b0;
         r_overrun <= 1'b0;
         r_break   <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         r_break   <= w_break;
         if (w_deliver && (!r_valid || rx_ready)) begin
            r_data   <= r_shift;
            r_perr_o <= r_perr;
            r_ferr_o <= w_ferr_fin;
            r_valid  <= 1'b1;
         end else begin
            if (w_deliver)           r_overrun <= 1'b1;
            if (r_valid && rx_ready) r_valid   <= 1'b0;
         end
      end
   end

   assign rx_data    = r_data;
   assign rx_valid   = r_valid;
   assign parity_err = r_perr_o;
   assign frame_err  = r_ferr_o;
   assign overrun    = r_overrun;
   assign break_det  = r_break;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg: directed frames plus randomized frames against
// a frame-level reference model of the UART rules.
module tb_uart_rx_cfg;
   localparam int CW = 16;
   localparam int SS = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          rx;
   logic [CW-1:0] wait_cycles;
   logic [1:0]    data_bits;
   logic [1:0]    parity_mode;
   logic          two_stop;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          parity_err;
   logic          frame_err;
   logic          overrun;
   logic          break_det;

   uart_rx_cfg #(.CNT_WIDTH(CW), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rst_n(rst_n), .rx(rx), .wait_cycles(wait_cycles),
      .data_bits(data_bits), .parity_mode(parity_mode), .two_stop(two_stop),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .parity_err(parity_err), .frame_err(frame_err),
      .overrun(overrun), .break_det(break_det)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Current frame format as the bench intends it
   int c_w, c_nb, c_pm, c_ts;

   logic [9:0] obs_q[$];
   int brk_cnt = 0;
   int ovr_cnt = 0;

   // Single comparison point
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Record accepted frames and pulses away from the active edge
   always @(negedge clk) begin
      if (rx_valid && rx_ready) obs_q.push_back({parity_err, frame_err, rx_data});
      if (break_det) brk_cnt++;
      if (overrun)   ovr_cnt++;
   end

   task automatic set_cfg(input int w, input int nb, input int pm, input int ts);
      c_w = w; c_nb = nb; c_pm = pm; c_ts = ts;
   endtask

   task automatic apply_cfg();
      wait_cycles = CW'(c_w);
      data_bits   = 2'(c_nb - 5);
      parity_mode = 2'(c_pm);
      two_stop    = 1'(c_ts);
   endtask

   // Drive one line level for cyc clocks; called and returns at posedge+1
   task automatic bit_out(input logic b, input int cyc);
      rx = b;
      repeat (cyc) @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] dmask();
      return 8'((1 << c_nb) - 1);
   endfunction

   function automatic logic good_par(input logic [7:0] d);
      return (^(d & dmask())) ^ (c_pm == 2);
   endfunction

   // Reference: {break, parity_err, frame_err, data} from the frame rules
   function automatic logic [10:0] model(input logic [7:0] d, input logic p,
                                         input logic s1, input logic s2);
      logic [7:0] data;
      logic       ones, pe, perr, ferr, brk;
      data = d & dmask();
      ones = ^data;
      pe   = (c_pm == 1) || (c_pm == 2);
      perr = (c_pm == 1) ? (ones ^ p) : (c_pm == 2) ? ~(ones ^ p) : 1'b0;
      ferr = !s1 || ((c_ts != 0) && !s2);
      brk  = (data == 8'h00) && (!pe || !p) && !s1;
      return {brk, perr, ferr, data};
   endfunction

   // Serialise one frame, scrambling config pins mid-frame, then idle high
   task automatic send_frame(input logic [7:0] d, input logic p, input logic s1, input logic s2);
      int per;
      per = c_w + 1;
      apply_cfg();
      bit_out(1'b0, per);
      for (int i = 0; i < c_nb; i++) bit_out(d[i], per);
      if (c_pm == 1 || c_pm == 2) bit_out(p, per);
      wait_cycles = CW'($urandom);
      data_bits   = 2'($urandom);
      parity_mode = 2'($urandom);
      two_stop    = 1'($urandom);
      bit_out(s1, per);
      if (c_ts != 0) bit_out(s2, per);
      bit_out(1'b1, 2 * per + SS + 4);
   endtask

   // Send a frame with rx_ready=1 and check against the model
   task automatic run_frame(input string tag, input logic [7:0] d, input logic flip,
                            input logic s1, input logic s2);
      logic [10:0] e;
      logic        p;
      int          b0, o0;
      p  = good_par(d) ^ flip;
      e  = model(d, p, s1, s2);
      b0 = brk_cnt;
      o0 = ovr_cnt;
      obs_q.delete();
      send_frame(d, p, s1, s2);
      chk({tag, "_ovr"}, ovr_cnt - o0, 0);
      if (e[10]) begin
         chk({tag, "_brk"}, brk_cnt - b0, 1);
         chk({tag, "_nvalid"}, obs_q.size(), 0);
      end else begin
         chk({tag, "_brk"}, brk_cnt - b0, 0);
         chk({tag, "_nvalid"}, obs_q.size(), 1);
         if (obs_q.size() > 0) begin
            chk({tag, "_data"}, obs_q[0][7:0], e[7:0]);
            chk({tag, "_perr"}, obs_q[0][9], e[9]);
            chk({tag, "_ferr"}, obs_q[0][8], e[8]);
         end
      end
   endtask

   initial begin
      int b0, o0, per;
      logic [7:0] d;
      rst_n = 1'b0; rx = 1'b1; rx_ready = 1'b1;
      set_cfg(9, 8, 0, 0);
      apply_cfg();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outs", {rx_valid, rx_data, parity_err, frame_err, overrun, break_det}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bit_out(1'b1, 5);

      // 8N1 basic
      set_cfg(9, 8, 0, 0);
      run_frame("8n1_a5", 8'hA5, 1'b0, 1'b1, 1'b1);

      // 7E1 with good and bad parity
      set_cfg(9, 7, 1, 0);
      run_frame("7e1_ok", 8'h35, 1'b0, 1'b1, 1'b1);
      run_frame("7e1_bad", 8'h35, 1'b1, 1'b1, 1'b1);

      // 5O2 with second stop low
      set_cfg(9, 5, 2, 1);
      run_frame("5o2_fe", 8'h1F, 1'b0, 1'b1, 1'b0);

      // Start-bit glitch is filtered, next frame still received
      set_cfg(9, 8, 0, 0);
      apply_cfg();
      obs_q.delete();
      b0 = brk_cnt;
      bit_out(1'b0, 3);
      bit_out(1'b1, 40);
      chk("glitch_nvalid", obs_q.size(), 0);
      chk("glitch_brk", brk_cnt - b0, 0);
      run_frame("post_glitch", 8'h3C, 1'b0, 1'b1, 1'b1);

      // Overrun: hold ready low across two frames
      rx_ready = 1'b0;
      obs_q.delete();
      o0 = ovr_cnt;
      send_frame(8'h11, 1'b0, 1'b1, 1'b1);
      send_frame(8'h22, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      chk("ovr_valid", rx_valid, 1);
      chk("ovr_data", rx_data, 8'h11);
      chk("ovr_pulses", ovr_cnt - o0, 1);
      @(posedge clk); #1;
      rx_ready = 1'b1;
      @(posedge clk); #1;
      rx_ready = 1'b0;
      @(negedge clk);
      chk("pop_valid", rx_valid, 0);
      chk("pop_count", obs_q.size(), 1);
      if (obs_q.size() > 0) chk("pop_data", obs_q[0][7:0], 8'h11);
      @(posedge clk); #1;
      rx_ready = 1'b1;

      // Break: line low 30 bit periods
      set_cfg(9, 8, 0, 0);
      apply_cfg();
      obs_q.delete();
      b0 = brk_cnt;
      bit_out(1'b0, 300);
      bit_out(1'b1, 30);
      chk("break_pulses", brk_cnt - b0, 1);
      chk("break_nvalid", obs_q.size(), 0);
      run_frame("post_break", 8'h7E, 1'b0, 1'b1, 1'b1);

      // Reset mid-byte with a pending frame
      rx_ready = 1'b0;
      send_frame(8'h5A, good_par(8'h5A), 1'b1, 1'b1);
      chk("pre_rst_valid", rx_valid, 1);
      per = c_w + 1;
      bit_out(1'b0, per);
      bit_out(1'b1, per);
      bit_out(1'b0, per);
      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("midrst_outs", {rx_valid, rx_data, parity_err, frame_err, overrun, break_det}, 0);
      @(posedge clk); #1;
      rst_n    = 1'b1;
      rx_ready = 1'b1;
      obs_q.delete();
      b0 = brk_cnt;
      o0 = ovr_cnt;
      bit_out(1'b1, 15 * per);
      chk("midrst_nvalid", obs_q.size(), 0);
      chk("midrst_brk", brk_cnt - b0, 0);
      chk("midrst_ovr", ovr_cnt - o0, 0);
      run_frame("post_rst", 8'hC3, 1'b0, 1'b1, 1'b1);

      // Randomized frames across formats, including one-cycle bits
      for (int k = 0; k < 30; k++) begin
         set_cfg(int'($urandom_range(0, 6)), int'($urandom_range(5, 8)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
         d = 8'($urandom);
         if ($urandom_range(0, 5) == 0) d = 8'h00;
         run_frame($sformatf("rnd%0d", k), d, 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) != 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
